// File: rtl/rni_aw_segq_if.sv
// rni_aw_segq_if: segment capture, TXREQ issue and TxnID release signals.
// The width macros default to the RNI build values when not already set.
`ifndef AXI4_AWADDR_WIDTH
`define AXI4_AWADDR_WIDTH 32
`endif
`ifndef RNI_BCVEC_WIDTH
`define RNI_BCVEC_WIDTH 4
`endif
`ifndef RNI_DMASK_WIDTH
`define RNI_DMASK_WIDTH 16
`endif
`ifndef CHIE_REQ_FLIT_SIZE_WIDTH
`define CHIE_REQ_FLIT_SIZE_WIDTH 3
`endif

interface rni_aw_segq_if #(
    parameter int TXN_NUM     = 8,
    parameter int TXNID_WIDTH = 3
);
    logic                                 seg_valid_s1_i;
    logic [`AXI4_AWADDR_WIDTH-1:0]        seg_addr_s1_i;
    logic                                 seg_done_s1_i;
    logic [`RNI_BCVEC_WIDTH-1:0]          seg_bc_vec_s2_i;
    logic [`RNI_DMASK_WIDTH-1:0]          seg_dmask_s2_i;
    logic [`CHIE_REQ_FLIT_SIZE_WIDTH-1:0] seg_size_s2_i;
    logic                                 seg_lock_s2_i;
    logic                                 stall_flag_s1_o;
    logic                                 req_valid_o;
    logic                                 req_ready_i;
    logic [`AXI4_AWADDR_WIDTH-1:0]        req_addr_o;
    logic [`RNI_BCVEC_WIDTH-1:0]          req_bc_vec_o;
    logic [`RNI_DMASK_WIDTH-1:0]          req_dmask_o;
    logic [`CHIE_REQ_FLIT_SIZE_WIDTH-1:0] req_size_o;
    logic                                 req_lock_o;
    logic                                 req_last_o;
    logic [TXNID_WIDTH-1:0]               req_txnid_o;
    logic                                 txn_rel_valid_i;
    logic [TXNID_WIDTH-1:0]               txn_rel_id_i;
    logic [TXN_NUM-1:0]                   txn_busy_o;
    logic                                 rel_err_o;

    modport slave (
        input  seg_valid_s1_i, seg_addr_s1_i, seg_done_s1_i,
        input  seg_bc_vec_s2_i, seg_dmask_s2_i, seg_size_s2_i,
        input  seg_lock_s2_i, req_ready_i,
        input  txn_rel_valid_i, txn_rel_id_i,
        output stall_flag_s1_o, req_valid_o, req_addr_o,
        output req_bc_vec_o, req_dmask_o, req_size_o,
        output req_lock_o, req_last_o, req_txnid_o,
        output txn_busy_o, rel_err_o
    );

    modport master (
        output seg_valid_s1_i, seg_addr_s1_i, seg_done_s1_i,
        output seg_bc_vec_s2_i, seg_dmask_s2_i, seg_size_s2_i,
        output seg_lock_s2_i, req_ready_i,
        output txn_rel_valid_i, txn_rel_id_i,
        input  stall_flag_s1_o, req_valid_o, req_addr_o,
        input  req_bc_vec_o, req_dmask_o, req_size_o,
        input  req_lock_o, req_last_o, req_txnid_o,
        input  txn_busy_o, rel_err_o
    );
endinterface

// File: rtl/rni_aw_segq.sv
// rni_aw_segq: AW segment queue with CHI TxnID allocation toward TXREQ.
// Optional macro RNI_AW_SEGQ_BYPASS_EN lets an S2 segment skip an empty queue.
`ifndef AXI4_AWADDR_WIDTH
`define AXI4_AWADDR_WIDTH 32
`endif
`ifndef RNI_BCVEC_WIDTH
`define RNI_BCVEC_WIDTH 4
`endif
`ifndef RNI_DMASK_WIDTH
`define RNI_DMASK_WIDTH 16
`endif
`ifndef CHIE_REQ_FLIT_SIZE_WIDTH
`define CHIE_REQ_FLIT_SIZE_WIDTH 3
`endif

module rni_aw_segq #(
    parameter int SEGQ_DEPTH  = 4,
    parameter int TXN_NUM     = 8,
    parameter int TXNID_WIDTH = 3
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    rni_aw_segq_if.slave bus
);
    localparam int AW = `AXI4_AWADDR_WIDTH;
    localparam int BW = `RNI_BCVEC_WIDTH;
    localparam int MW = `RNI_DMASK_WIDTH;
    localparam int SW = `CHIE_REQ_FLIT_SIZE_WIDTH;
    localparam int PW = $clog2(SEGQ_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          last;
        logic [BW-1:0] bc_vec;
        logic [MW-1:0] dmask;
        logic [SW-1:0] size;
        logic          lock;
    } seg_ent_t;

    seg_ent_t               mem_q [SEGQ_DEPTH];
    logic [PW-1:0]          rd_ptr_q;
    logic [PW-1:0]          wr_ptr_q;
    logic [CW-1:0]          count_q;
    logic                   s2_vld_q;
    logic [AW-1:0]          s2_addr_q;
    logic                   s2_done_q;
    logic [TXN_NUM-1:0]     busy_q;
    logic [TXN_NUM-1:0]     busy_d;
    logic                   hold_vld_q;
    logic [TXNID_WIDTH-1:0] hold_id_q;
    logic                   rel_err_q;

    logic                   empty;
    logic                   stall;
    logic                   s1_acc;
    logic                   byp;
    logic                   fire;
    logic                   push;
    logic                   pop;
    logic                   any_free;
    logic                   rel_ok;
    logic                   rel_hit;
    logic [CW:0]            occ;
    logic [TXNID_WIDTH-1:0] free_id;
    logic [TXNID_WIDTH-1:0] offer_id;
    seg_ent_t               s2_ent;
    seg_ent_t               out_ent;

    assign empty  = (count_q == '0);
    assign occ    = (CW+1)'(count_q) + (CW+1)'(s2_vld_q);
    assign stall  = (occ >= (CW+1)'(SEGQ_DEPTH));
    assign s1_acc = bus.seg_valid_s1_i & ~stall;

    assign s2_ent.addr   = s2_addr_q;
    assign s2_ent.last   = s2_done_q;
    assign s2_ent.bc_vec = bus.seg_bc_vec_s2_i;
    assign s2_ent.dmask  = bus.seg_dmask_s2_i;
    assign s2_ent.size   = bus.seg_size_s2_i;
    assign s2_ent.lock   = bus.seg_lock_s2_i;

`ifdef RNI_AW_SEGQ_BYPASS_EN
    assign byp = empty & s2_vld_q;
`else
    assign byp = 1'b0;
`endif

    assign out_ent = byp ? s2_ent : mem_q[rd_ptr_q];

    // Lowest free TxnID in the pool.
    always_comb begin
        free_id  = '0;
        any_free = 1'b0;
        for (int i = TXN_NUM - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_id  = TXNID_WIDTH'(i);
                any_free = 1'b1;
            end
        end
    end

    // A stalled offer keeps its ID even if a lower one is released.
    assign offer_id = hold_vld_q ? hold_id_q : free_id;

    assign bus.req_valid_o = (~empty | byp) & any_free;
    assign fire = bus.req_valid_o & bus.req_ready_i;
    assign pop  = fire & ~byp;
    assign push = s2_vld_q & ~(byp & fire);

    assign rel_ok  = 32'(bus.txn_rel_id_i) < 32'(TXN_NUM);
    assign rel_hit = bus.txn_rel_valid_i & rel_ok
                   & busy_q[bus.txn_rel_id_i];

    // Next busy map: set on fire, clear on a legal release.
    always_comb begin
        busy_d = busy_q;
        if (fire) begin
            busy_d[offer_id] = 1'b1;
        end
        if (rel_hit) begin
            busy_d[bus.txn_rel_id_i] = 1'b0;
        end
    end

    // S1 capture into the S2 staging register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s2_vld_q  <= 1'b0;
            s2_addr_q <= '0;
            s2_done_q <= 1'b0;
        end else begin
            s2_vld_q <= s1_acc;
            if (s1_acc) begin
                s2_addr_q <= bus.seg_addr_s1_i;
                s2_done_q <= bus.seg_done_s1_i;
            end
        end
    end

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < SEGQ_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= s2_ent;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // TxnID pool, offer hold and release error pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q     <= '0;
            hold_vld_q <= 1'b0;
            hold_id_q  <= '0;
            rel_err_q  <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            hold_vld_q <= bus.req_valid_o & ~bus.req_ready_i;
            hold_id_q  <= offer_id;
            rel_err_q  <= bus.txn_rel_valid_i & ~rel_hit;
        end
    end

    assign bus.stall_flag_s1_o = stall;
    assign bus.req_addr_o      = out_ent.addr;
    assign bus.req_bc_vec_o    = out_ent.bc_vec;
    assign bus.req_dmask_o     = out_ent.dmask;
    assign bus.req_size_o      = out_ent.size;
    assign bus.req_lock_o      = out_ent.lock;
    assign bus.req_last_o      = out_ent.last;
    assign bus.req_txnid_o     = offer_id;
    assign bus.txn_busy_o      = busy_q;
    assign bus.rel_err_o       = rel_err_q;

endmodule

// File: tb/tb_rni_aw_segq.sv
// tb_rni_aw_segq: scoreboard bench for the AW segment queue.
// Expected segments are queued on S1 accept and compared on each fire.
`timescale 1ns/1ps
`ifndef AXI4_AWADDR_WIDTH
`define AXI4_AWADDR_WIDTH 32
`endif
`ifndef RNI_BCVEC_WIDTH
`define RNI_BCVEC_WIDTH 4
`endif
`ifndef RNI_DMASK_WIDTH
`define RNI_DMASK_WIDTH 16
`endif
`ifndef CHIE_REQ_FLIT_SIZE_WIDTH
`define CHIE_REQ_FLIT_SIZE_WIDTH 3
`endif

module tb_rni_aw_segq;
    localparam int DEPTH = 4;
    localparam int TXN   = 8;
    localparam int IDW   = 3;
`ifdef RNI_AW_SEGQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [`AXI4_AWADDR_WIDTH-1:0]        addr;
        logic                                 done;
        logic [`RNI_BCVEC_WIDTH-1:0]          bc;
        logic [`RNI_DMASK_WIDTH-1:0]          dmask;
        logic [`CHIE_REQ_FLIT_SIZE_WIDTH-1:0] size;
        logic                                 lock;
    } seg_t;

    logic clk;
    logic rst_n;

    rni_aw_segq_if #(.TXN_NUM(TXN), .TXNID_WIDTH(IDW)) bus ();

    rni_aw_segq #(
        .SEGQ_DEPTH (DEPTH),
        .TXN_NUM    (TXN),
        .TXNID_WIDTH(IDW)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    int       nacc = 0;
    int       nfire = 0;
    int       acc_cyc = 0;
    int       fire_cyc = 0;
    int       rel_cyc = 0;
    int       stall_acc = -1;
    logic [IDW-1:0] fire_id = '0;
    logic [TXN-1:0] mbusy = '0;
    logic     exp_err = 1'b0;
    seg_t     src_q[$];
    seg_t     sb_q[$];

    function automatic logic [IDW-1:0] lowest_free(input logic [TXN-1:0] b);
        logic [IDW-1:0] r;
        r = '0;
        for (int i = TXN - 1; i >= 0; i--) begin
            if (!b[i]) r = IDW'(i);
        end
        return r;
    endfunction

    function automatic seg_t mk(input logic [31:0] a, input logic d,
                                input logic l);
        seg_t s;
        s.addr  = a;
        s.done  = d;
        s.bc    = a[7:4] ^ 4'h9;
        s.dmask = a[15:0] ^ 16'ha5c3;
        s.size  = a[10:8];
        s.lock  = l;
        return s;
    endfunction

    task automatic drive_s1();
        if (src_q.size() > 0) begin
            bus.seg_valid_s1_i = 1'b1;
            bus.seg_addr_s1_i  = src_q[0].addr;
            bus.seg_done_s1_i  = src_q[0].done;
        end else begin
            bus.seg_valid_s1_i = 1'b0;
            bus.seg_addr_s1_i  = '0;
            bus.seg_done_s1_i  = 1'b0;
        end
    endtask

    task automatic feed(input seg_t s);
        src_q.push_back(s);
        drive_s1();
    endtask

    // One cycle: sample at negedge, update drives just after posedge.
    task automatic tick();
        seg_t     exp;
        seg_t     got;
        seg_t     s;
        logic     acc;
        logic     fire;
        logic     rel_legal;
        logic [IDW-1:0] eid;
        @(negedge clk);
        cyc++;
        checks++;
        if (bus.rel_err_o !== exp_err) begin
            errors++;
            $display("FAIL rel_err cyc %0d: got %b expected %b",
                     cyc, bus.rel_err_o, exp_err);
        end
        if (stall_acc < 0 && bus.stall_flag_s1_o === 1'b1) stall_acc = nacc;
        acc  = bus.seg_valid_s1_i & ~bus.stall_flag_s1_o;
        fire = bus.req_valid_o & bus.req_ready_i;
        rel_legal = bus.txn_rel_valid_i & mbusy[bus.txn_rel_id_i];
        exp_err = bus.txn_rel_valid_i & ~rel_legal;
        if (acc) begin
            nacc++;
            acc_cyc = cyc;
        end
        if (fire) begin
            nfire++;
            fire_cyc = cyc;
            fire_id  = bus.req_txnid_o;
            got.addr  = bus.req_addr_o;
            got.done  = bus.req_last_o;
            got.bc    = bus.req_bc_vec_o;
            got.dmask = bus.req_dmask_o;
            got.size  = bus.req_size_o;
            got.lock  = bus.req_lock_o;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL fire_unexpected cyc %0d: got addr %h expected none",
                         cyc, got.addr);
            end else begin
                exp = sb_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL fire_payload cyc %0d: got %h expected %h",
                             cyc, got, exp);
                end
            end
            eid = lowest_free(mbusy);
            checks++;
            if (bus.req_txnid_o !== eid) begin
                errors++;
                $display("FAIL fire_txnid cyc %0d: got %0d expected %0d",
                         cyc, bus.req_txnid_o, eid);
            end
            mbusy[eid] = 1'b1;
        end
        if (bus.txn_rel_valid_i) begin
            rel_cyc = cyc;
            if (rel_legal) mbusy[bus.txn_rel_id_i] = 1'b0;
        end
        @(posedge clk);
        #1;
        if (acc) begin
            s = src_q.pop_front();
            sb_q.push_back(s);
            bus.seg_bc_vec_s2_i = s.bc;
            bus.seg_dmask_s2_i  = s.dmask;
            bus.seg_size_s2_i   = s.size;
            bus.seg_lock_s2_i   = s.lock;
        end else begin
            bus.seg_bc_vec_s2_i = 4'($urandom);
            bus.seg_dmask_s2_i  = 16'($urandom);
            bus.seg_size_s2_i   = 3'($urandom);
            bus.seg_lock_s2_i   = 1'($urandom);
        end
        drive_s1();
        bus.txn_rel_valid_i = 1'b0;
    endtask

    task automatic wait_fires(input int n, input int budget);
        int start;
        start = nfire;
        for (int i = 0; i < budget && (nfire - start) < n; i++) tick();
    endtask

    task automatic release_all();
        for (int i = 0; i < TXN; i++) begin
            if (mbusy[i]) begin
                bus.txn_rel_valid_i = 1'b1;
                bus.txn_rel_id_i    = IDW'(i);
                tick();
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.seg_valid_s1_i  = 1'b0;
        bus.seg_addr_s1_i   = '0;
        bus.seg_done_s1_i   = 1'b0;
        bus.seg_bc_vec_s2_i = '0;
        bus.seg_dmask_s2_i  = '0;
        bus.seg_size_s2_i   = '0;
        bus.seg_lock_s2_i   = 1'b0;
        bus.req_ready_i     = 1'b0;
        bus.txn_rel_valid_i = 1'b0;
        bus.txn_rel_id_i    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if ({bus.req_valid_o, bus.stall_flag_s1_o, bus.rel_err_o,
             bus.req_last_o, bus.req_lock_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.req_valid_o, bus.stall_flag_s1_o, bus.rel_err_o,
                      bus.req_last_o, bus.req_lock_o});
        end
        checks++;
        if (bus.txn_busy_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_busy: got %h expected 00", bus.txn_busy_o);
        end
        checks++;
        if (bus.req_txnid_o !== 3'd0 || bus.req_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_req: got id %0d addr %h expected 0 0",
                     bus.req_txnid_o, bus.req_addr_o);
        end
    endtask

    task automatic test_single();
        int f0;
        f0 = nfire;
        bus.req_ready_i = 1'b1;
        feed(mk(32'h1000, 1'b1, 1'b0));
        wait_fires(1, 10);
        checks++;
        if (nfire - f0 != 1) begin
            errors++;
            $display("FAIL single_fire: got %0d fires expected 1", nfire - f0);
        end
        checks++;
        if (fire_cyc - acc_cyc != LAT) begin
            errors++;
            $display("FAIL single_latency: got %0d expected %0d",
                     fire_cyc - acc_cyc, LAT);
        end
        checks++;
        if (fire_id !== 3'd0) begin
            errors++;
            $display("FAIL single_id: got %0d expected 0", fire_id);
        end
        release_all();
        checks++;
        if (bus.txn_busy_o !== 8'h00) begin
            errors++;
            $display("FAIL single_free: got %h expected 00", bus.txn_busy_o);
        end
    endtask

    task automatic test_back_to_back();
        int a0;
        int f0;
        a0 = nacc;
        f0 = nfire;
        stall_acc = -1;
        bus.req_ready_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            feed(mk(32'h100 * (k + 1), k == 5, k[0]));
        end
        repeat (8) tick();
        checks++;
        if (bus.stall_flag_s1_o !== 1'b1 || stall_acc - a0 != 4) begin
            errors++;
            $display("FAIL b2b_stall: got flag %b at accept %0d expected 1 at 4",
                     bus.stall_flag_s1_o, stall_acc - a0);
        end
        checks++;
        if (nacc - a0 != 4 || bus.req_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold: got %0d accepts valid %b expected 4 1",
                     nacc - a0, bus.req_valid_o);
        end
        bus.req_ready_i = 1'b1;
        wait_fires(6, 40);
        checks++;
        if (nfire - f0 != 6 || sb_q.size() != 0 || src_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: got %0d fires expected 6", nfire - f0);
        end
        release_all();
        checks++;
        if (bus.txn_busy_o !== 8'h00) begin
            errors++;
            $display("FAIL b2b_free: got %h expected 00", bus.txn_busy_o);
        end
    endtask

    task automatic test_exhaust();
        int f0;
        bus.req_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            feed(mk(32'h4000 + 32'h40 * k, 1'b1, 1'b0));
        end
        wait_fires(8, 60);
        checks++;
        if (bus.txn_busy_o !== 8'hff) begin
            errors++;
            $display("FAIL exhaust_busy: got %h expected ff", bus.txn_busy_o);
        end
        f0 = nfire;
        feed(mk(32'h5000, 1'b1, 1'b1));
        repeat (5) tick();
        checks++;
        if (bus.req_valid_o !== 1'b0 || nfire != f0) begin
            errors++;
            $display("FAIL exhaust_block: got valid %b fires %0d expected 0 0",
                     bus.req_valid_o, nfire - f0);
        end
        bus.txn_rel_valid_i = 1'b1;
        bus.txn_rel_id_i    = 3'd5;
        tick();
        wait_fires(1, 10);
        checks++;
        if (fire_id !== 3'd5 || fire_cyc != rel_cyc + 1) begin
            errors++;
            $display("FAIL exhaust_resume: got id %0d after %0d cycles expected 5 after 1",
                     fire_id, fire_cyc - rel_cyc);
        end
        release_all();
    endtask

    task automatic test_rel_err();
        bus.req_ready_i = 1'b1;
        feed(mk(32'h6000, 1'b1, 1'b0));
        wait_fires(1, 10);
        tick();
        bus.txn_rel_valid_i = 1'b1;
        bus.txn_rel_id_i    = 3'd3;
        tick();
        checks++;
        if (bus.rel_err_o !== 1'b1 || bus.txn_busy_o !== 8'h01) begin
            errors++;
            $display("FAIL rel_err_pulse: got err %b busy %h expected 1 01",
                     bus.rel_err_o, bus.txn_busy_o);
        end
        tick();
        checks++;
        if (bus.rel_err_o !== 1'b0) begin
            errors++;
            $display("FAIL rel_err_clear: got %b expected 0", bus.rel_err_o);
        end
    endtask

    task automatic test_rel_fire();
        bus.req_ready_i = 1'b0;
        feed(mk(32'h7000, 1'b0, 1'b1));
        for (int i = 0; i < 10 && bus.req_valid_o !== 1'b1; i++) tick();
        checks++;
        if (bus.req_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL relfire_wait: got valid %b expected 1", bus.req_valid_o);
        end
        bus.req_ready_i     = 1'b1;
        bus.txn_rel_valid_i = 1'b1;
        bus.txn_rel_id_i    = 3'd0;
        tick();
        checks++;
        if (bus.txn_busy_o !== 8'h02 || bus.rel_err_o !== 1'b0
            || fire_id !== 3'd1) begin
            errors++;
            $display("FAIL relfire_busy: got busy %h err %b id %0d expected 02 0 1",
                     bus.txn_busy_o, bus.rel_err_o, fire_id);
        end
        release_all();
    endtask

    task automatic test_reset_mid();
        int f0;
        bus.req_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            feed(mk(32'h8000 + 32'h10 * k, 1'b1, 1'b0));
        end
        wait_fires(4, 30);
        bus.req_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            feed(mk(32'h9000 + 32'h10 * k, k == 2, 1'b1));
        end
        repeat (6) tick();
        checks++;
        if (bus.txn_busy_o !== 8'h0f || bus.req_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got busy %h valid %b expected 0f 1",
                     bus.txn_busy_o, bus.req_valid_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_valid_o, bus.stall_flag_s1_o, bus.req_last_o,
             bus.req_lock_o, bus.txn_busy_o} !== 12'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h expected 000",
                     {bus.req_valid_o, bus.stall_flag_s1_o, bus.req_last_o,
                      bus.req_lock_o, bus.txn_busy_o});
        end
        checks++;
        if (bus.req_addr_o !== 32'h0 || bus.req_txnid_o !== 3'd0) begin
            errors++;
            $display("FAIL midrst_req: got addr %h id %0d expected 0 0",
                     bus.req_addr_o, bus.req_txnid_o);
        end
        src_q.delete();
        sb_q.delete();
        mbusy   = '0;
        exp_err = 1'b0;
        drive_s1();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        f0 = nfire;
        bus.req_ready_i = 1'b1;
        feed(mk(32'h2000, 1'b1, 1'b0));
        wait_fires(1, 10);
        checks++;
        if (nfire - f0 != 1 || fire_id !== 3'd0) begin
            errors++;
            $display("FAIL midrst_first: got %0d fires id %0d expected 1 0",
                     nfire - f0, fire_id);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_exhaust();
        test_rel_err();
        test_rel_fire();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
